// File: rtl/adder_accum_nbit.sv
// adder_accum_nbit: saturating frame accumulator for adder sums with valid/ready input and held valid/ack result
module adder_accum_nbit #(
  parameter int N     = 10,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic [N:0]       sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ack,
  output logic             overflow,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [4:0]       remaining;
  logic             ovf;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_sat;
  logic             xfer;
  logic             last;
  // one extra bit catches the carry that triggers clamping to all-ones
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W - N){1'b0}}, sum_in};
    sum_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    xfer    = sum_valid && (state == ACCUM);
    last    = xfer && (remaining == 5'd1);
  end
  // next-state: start only honoured in IDLE, ack only in HOLD
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? ACCUM : IDLE;
      ACCUM:   state_nxt = last ? HOLD : ACCUM;
      HOLD:    state_nxt = acc_ack ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end
  // accumulator, sticky overflow and sample counter; len of 0 stands for 16
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE && start) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= (len == 4'd0) ? 5'd16 : {1'b0, len};
    end else if (xfer) begin
      acc       <= sum_sat;
      ovf       <= ovf | sum_ext[ACC_W];
      remaining <= remaining - 5'd1;
    end
  end
  assign sum_ready = (state == ACCUM);
  assign acc_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign overflow  = ovf;
endmodule

// File: tb/tb_adder_accum_nbit.sv
// tb_adder_accum_nbit: directed vector table plus hand sequences for reset, full length, saturation and ignored start
module tb_adder_accum_nbit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_start, a_sv, a_ack;
  logic [3:0]  a_len;
  logic [10:0] a_sum;
  logic        a_ready, a_valid, a_ovf, a_busy;
  logic [15:0] a_acc;
  logic        b_start, b_sv, b_ack;
  logic [3:0]  b_len;
  logic [10:0] b_sum;
  logic        b_ready, b_valid, b_ovf, b_busy;
  logic [11:0] b_acc;
  int          total = 0;
  int          passed = 0;
  typedef struct {
    logic        start;
    logic [3:0]  len;
    logic        sv;
    logic [10:0] sum;
    logic        ack;
    logic        ready;
    logic        valid;
    logic [15:0] acc;
    logic        ovf;
    logic        busy;
  } vec_t;
  vec_t v[$];
  adder_accum_nbit #(.N(10), .ACC_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .len(a_len), .sum_in(a_sum),
    .sum_valid(a_sv), .sum_ready(a_ready), .acc_out(a_acc), .acc_valid(a_valid),
    .acc_ack(a_ack), .overflow(a_ovf), .busy(a_busy));
  adder_accum_nbit #(.N(10), .ACC_W(12)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .len(b_len), .sum_in(b_sum),
    .sum_valid(b_sv), .sum_ready(b_ready), .acc_out(b_acc), .acc_valid(b_valid),
    .acc_ack(b_ack), .overflow(b_ovf), .busy(b_busy));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask
  task automatic chk_a(input string tag, input int rdy, input int vld, input int acc, input int ovf, input int bsy);
    chk({tag, " ready"}, {31'd0, a_ready}, rdy);
    chk({tag, " valid"}, {31'd0, a_valid}, vld);
    chk({tag, " acc"}, {16'd0, a_acc}, acc);
    chk({tag, " ovf"}, {31'd0, a_ovf}, ovf);
    chk({tag, " busy"}, {31'd0, a_busy}, bsy);
  endtask
  task automatic row(input int s, input int l, input int sv, input int sum, input int ack,
                     input int rdy, input int vld, input int acc, input int ovf, input int bsy);
    vec_t r;
    r.start = s[0]; r.len = l[3:0]; r.sv = sv[0]; r.sum = sum[10:0]; r.ack = ack[0];
    r.ready = rdy[0]; r.valid = vld[0]; r.acc = acc[15:0]; r.ovf = ovf[0]; r.busy = bsy[0];
    v.push_back(r);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b1;
    a_start = 0; a_len = 0; a_sv = 0; a_sum = 0; a_ack = 0;
    b_start = 0; b_len = 0; b_sv = 0; b_sum = 0; b_ack = 0;
    #2 reset_n = 1'b0;
    #1 chk_a("async reset", 0, 0, 0, 0, 0);
    a_start = 1; a_len = 4;
    step;
    chk_a("start under reset", 0, 0, 0, 0, 0);
    a_start = 0;
    #3 reset_n = 1'b1;
    step;
    // basic frame: 99+99+147+0, held five cycles without ack, junk offered in HOLD
    row(1, 4, 0,   0, 0, 1, 0,   0, 0, 1);
    row(0, 0, 1,  99, 0, 1, 0,  99, 0, 1);
    row(0, 0, 1,  99, 0, 1, 0, 198, 0, 1);
    row(0, 0, 1, 147, 0, 1, 0, 345, 0, 1);
    row(0, 0, 1,   0, 0, 0, 1, 345, 0, 1);
    for (int i = 0; i < 5; i++) row(1, 2, 1, 7, 0, 0, 1, 345, 0, 1);
    row(0, 0, 0,   0, 1, 0, 0, 345, 0, 0);
    // bubbles: junk sums offered with sum_valid low are never added
    row(1, 3, 0,   0, 0, 1, 0,   0, 0, 1);
    row(0, 0, 1,   1, 0, 1, 0,   1, 0, 1);
    row(0, 0, 0, 500, 0, 1, 0,   1, 0, 1);
    row(0, 0, 0, 700, 0, 1, 0,   1, 0, 1);
    row(0, 0, 1,   2, 0, 1, 0,   3, 0, 1);
    row(0, 0, 0, 900, 0, 1, 0,   3, 0, 1);
    row(0, 0, 1,   3, 0, 0, 1,   6, 0, 1);
    row(0, 0, 0,   0, 1, 0, 0,   6, 0, 0);
    for (int i = 0; i < v.size(); i++) begin
      a_start = v[i].start; a_len = v[i].len; a_sv = v[i].sv; a_sum = v[i].sum; a_ack = v[i].ack;
      step;
      chk_a($sformatf("vec%0d", i), v[i].ready, v[i].valid, v[i].acc, v[i].ovf, v[i].busy);
    end
    a_start = 0; a_sv = 0; a_ack = 0;
    // full length: len 0 means 16 samples of 2047, result valid 17 cycles after start
    a_start = 1; a_len = 0;
    step;
    a_start = 0; a_sv = 1; a_sum = 11'd2047;
    for (int i = 0; i < 16; i++) begin
      step;
      if (i == 14) chk("full len not yet valid", {31'd0, a_valid}, 0);
    end
    chk_a("full len done", 0, 1, 32752, 0, 1);
    a_sv = 0; a_ack = 1;
    step;
    chk("full len ack", {31'd0, a_valid}, 0);
    a_ack = 0;
    // saturation on the 12-bit instance
    b_start = 1; b_len = 4;
    step;
    b_start = 0; b_sv = 1; b_sum = 11'd2047;
    step;
    chk("sat acc 1", {20'd0, b_acc}, 2047);
    step;
    chk("sat acc 2", {20'd0, b_acc}, 4094);
    step;
    chk("sat acc 3", {20'd0, b_acc}, 4095);
    chk("sat ovf 3", {31'd0, b_ovf}, 1);
    step;
    chk("sat acc 4", {20'd0, b_acc}, 4095);
    chk("sat ovf 4", {31'd0, b_ovf}, 1);
    chk("sat valid", {31'd0, b_valid}, 1);
    chk("sat ready", {31'd0, b_ready}, 0);
    b_sv = 0;
    step;
    chk("sat hold ovf", {31'd0, b_ovf}, 1);
    chk("sat hold acc", {20'd0, b_acc}, 4095);
    b_ack = 1;
    step;
    chk("sat idle ovf", {31'd0, b_ovf}, 1);
    chk("sat idle valid", {31'd0, b_valid}, 0);
    b_ack = 0; b_start = 1;
    step;
    chk("sat restart ovf", {31'd0, b_ovf}, 0);
    chk("sat restart acc", {20'd0, b_acc}, 0);
    b_start = 0;
    // reset in the middle of a frame discards it
    a_start = 1; a_len = 4;
    step;
    a_start = 0; a_sv = 1; a_sum = 11'd10;
    step;
    step;
    chk("mid acc before reset", {16'd0, a_acc}, 20);
    a_sv = 0;
    #2 reset_n = 1'b0;
    #1 chk_a("mid reset", 0, 0, 0, 0, 0);
    #2 reset_n = 1'b1;
    a_start = 1; a_len = 1;
    step;
    chk_a("len1 start", 1, 0, 0, 0, 1);
    a_start = 0; a_sv = 1; a_sum = 11'd5;
    step;
    chk_a("len1 done", 0, 1, 5, 0, 1);
    a_sv = 0; a_start = 1;
    step;
    chk_a("start in hold", 0, 1, 5, 0, 1);
    a_ack = 1;
    step;
    chk_a("start on ack", 0, 0, 5, 0, 0);
    a_ack = 0; a_start = 0;
    step;
    chk_a("stays idle", 0, 0, 5, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
